// File: rtl/bram_uart_loader.sv
// bram_uart_loader: boot-time loader that receives a program image over an
// 8N1 UART and writes 16-bit words into BRAM port B from address 0. The CPU
// datapath is held in reset until the image has loaded.
// Optional feature macro: LOADER_CHECKSUM_EN. When defined, an XOR checksum
// word follows the data, and a mismatch ends the load in ERROR.
module bram_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_data,
    output logic              mem_we,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [3:0] L_CNT_HI = 4'd0;
    localparam logic [3:0] L_CNT_LO = 4'd1;
    localparam logic [3:0] L_DAT_HI = 4'd2;
    localparam logic [3:0] L_DAT_LO = 4'd3;
    localparam logic [3:0] L_WRITE  = 4'd4;
    localparam logic [3:0] L_DONE   = 4'd5;
    localparam logic [3:0] L_ERR    = 4'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [3:0] L_CHK_HI = 4'd7;
    localparam logic [3:0] L_CHK_LO = 4'd8;
    localparam logic [3:0] L_AFTER_DATA = L_CHK_HI;
`else
    localparam logic [3:0] L_AFTER_DATA = L_DONE;
`endif

    // Receiver -> load FSM interface: byte_valid_q is a one-cycle pulse with
    // the byte in shift_q; frame_err_q is a one-cycle pulse on a bad stop
    // bit. There is no back-pressure: the FSM consumes a byte in its pulse
    // cycle, and shift_q holds steady until the next byte's data bits.
    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    logic [1:0]       rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             start_ok;

    logic [3:0]        state_q, state_d;
    logic [7:0]        cnt_hi_q, cnt_hi_d;
    logic [15:0]       rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              cpu_rst_q, cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]       chk_q, chk_d;
    logic [7:0]        chk_hi_q, chk_hi_d;
`endif

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= uart_rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // UART receiver: mid-bit start confirmation, then one sample per bit time.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        start_ok     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;   // glitch, not a start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        bit_idx_d  = '0;
                        start_ok   = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d  = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_s2_q) byte_valid_d = 1'b1;
                    else frame_err_d = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Load FSM: count, data words (optionally checksum), then DONE or ERROR.
    always_comb begin
        state_d   = state_q;
        cnt_hi_d  = cnt_hi_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy_q;
        cpu_rst_d = (state_q != L_DONE);
`ifdef LOADER_CHECKSUM_EN
        chk_d     = chk_q;
        chk_hi_d  = chk_hi_q;
`endif
        if (start_ok && state_q != L_DONE && state_q != L_ERR) busy_d = 1'b1;
        case (state_q)
            L_CNT_HI: if (byte_valid_q) begin
                cnt_hi_d = shift_q;
                state_d  = L_CNT_LO;
            end
            L_CNT_LO: if (byte_valid_q) begin
                if ({cnt_hi_q, shift_q} == 16'd0) begin
                    state_d = L_AFTER_DATA;
                end else if ({1'b0, cnt_hi_q, shift_q} > MAX_WORDS) begin
                    state_d = L_ERR;
                end else begin
                    rem_d   = {cnt_hi_q, shift_q};
                    state_d = L_DAT_HI;
                end
            end
            L_DAT_HI: if (byte_valid_q) begin
                data_d[15:8] = shift_q;
                state_d      = L_DAT_LO;
            end
            L_DAT_LO: if (byte_valid_q) begin
                data_d[7:0] = shift_q;
                state_d     = L_WRITE;
            end
            L_WRITE: begin
                // addr wraps to 0 after the last slot; harmless, FSM is finishing
                addr_d = addr_q + 1'b1;
                rem_d  = rem_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                chk_d  = chk_q ^ data_q;
`endif
                state_d = (rem_q == 16'd1) ? L_AFTER_DATA : L_DAT_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            L_CHK_HI: if (byte_valid_q) begin
                chk_hi_d = shift_q;
                state_d  = L_CHK_LO;
            end
            L_CHK_LO: if (byte_valid_q) begin
                state_d = ({chk_hi_q, shift_q} == chk_q) ? L_DONE : L_ERR;
            end
`endif
            L_DONE: state_d = L_DONE;
            L_ERR:  state_d = L_ERR;
            default: state_d = L_ERR;
        endcase
        if (frame_err_q && state_q != L_DONE && state_q != L_ERR) state_d = L_ERR;
        if (state_d == L_DONE || state_d == L_ERR) busy_d = 1'b0;
    end

    // State registers for receiver and load FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= L_CNT_HI;
            cnt_hi_q     <= '0;
            rem_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            busy_q       <= 1'b0;
            cpu_rst_q    <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= '0;
            chk_hi_q     <= '0;
`endif
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            rem_q        <= rem_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            cpu_rst_q    <= cpu_rst_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
            chk_hi_q     <= chk_hi_d;
`endif
        end
    end

    assign mem_addr = addr_q;
    assign mem_data = data_q;
    assign mem_we   = (state_q == L_WRITE);
    assign cpu_rst  = cpu_rst_q;
    assign busy     = busy_q;
    assign done     = (state_q == L_DONE);
    assign err      = (state_q == L_ERR);
endmodule

// File: tb/tb_bram_uart_loader.sv
// tb_bram_uart_loader: randomized and directed image streams for
// bram_uart_loader (CLKS_PER_BIT=4, ADDR_W=4), checked against a
// word-level model of the image format. Honours LOADER_CHECKSUM_EN.
module tb_bram_uart_loader;
  localparam int C    = 4;
  localparam int AW   = 4;
  localparam int MAXW = 1 << AW;
  localparam int TO   = 5000;

  logic          clk = 1'b0;
  logic          rst;
  logic          uart_rx;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          mem_we, cpu_rst, busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_stop_cyc = 0;
  bit check_en = 1'b0;
  bit prev_we = 1'b0;
  bit prev_done = 1'b0;
  logic [AW+15:0] exp_q[$];
  logic [15:0] img[0:MAXW-1];

  bram_uart_loader #(.CLKS_PER_BIT(C), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  // clock / cycle counter / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // compare process: every write against the scoreboard, plus output rules
  always @(negedge clk) begin
    if (!check_en) begin
      prev_we = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (mem_we) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", mem_addr, mem_data);
        end else begin
          logic [AW+15:0] e;
          e = exp_q.pop_front();
          if ({mem_addr, mem_data} !== e) begin
            errors++;
            $display("FAIL write_value: got addr=%0h data=%0h expected addr=%0h data=%0h",
                     mem_addr, mem_data, e[AW+15:16], e[15:0]);
          end
        end
        checks++;
        if ((cyc - last_stop_cyc) < 2 || (cyc - last_stop_cyc) > C + 4) begin
          errors++;
          $display("FAIL write_latency: %0d cycles after stop bit, expected 2..%0d", cyc - last_stop_cyc, C + 4);
        end
      end
      checks++;
      if ((mem_we && prev_we) || (done && err) || (busy && (done || err)) || (cpu_rst !== !prev_done)) begin
        errors++;
        $display("FAIL output_rules: we=%0b prev_we=%0b done=%0b err=%0b busy=%0b cpu_rst=%0b prev_done=%0b",
                 mem_we, prev_we, done, err, busy, cpu_rst, prev_done);
      end
      prev_we = mem_we;
      prev_done = done;
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (C) @(negedge clk);
    end
    last_stop_cyc = cyc;
    uart_rx = stop_ok;
    repeat (C) @(negedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {39'd0, mem_addr, mem_data, mem_we, cpu_rst, busy, done, err},
          {39'd0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err) && n < TO) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || err)) begin
      errors++;
      $display("FAIL wait_end: timeout, done=%0b err=%0b, expected one of them high", done, err);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic final_check(input string tag, input bit exp_done);
    check({tag, "_done"}, {63'd0, done}, {63'd0, exp_done});
    check({tag, "_err"}, {63'd0, err}, {63'd0, !exp_done});
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_cpu_rst"}, {63'd0, cpu_rst}, {63'd0, !exp_done});
    check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  // behavioural model: what the image should produce
  function automatic logic [15:0] xor_words(input int n);
    logic [15:0] x;
    x = 16'h0000;
    for (int i = 0; i < n; i++) x ^= img[i];
    return x;
  endfunction

  task automatic model_image(input int n, input logic [15:0] chk, output bit exp_done);
    if (n > MAXW) begin
      exp_done = 1'b0;
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back({AW'(i), img[i]});
`ifdef LOADER_CHECKSUM_EN
      exp_done = (xor_words(n) == chk);
`else
      exp_done = (chk == chk) ? 1'b1 : 1'b1;
`endif
    end
  endtask

  task automatic send_image(input logic [15:0] n, input int nwords, input logic [15:0] chk, input bit with_chk);
    send_byte(n[15:8], 1'b1);
    send_byte(n[7:0], 1'b1);
    for (int i = 0; i < nwords; i++) begin
      send_byte(img[i][15:8], 1'b1);
      send_byte(img[i][7:0], 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    if (with_chk) begin
      send_byte(chk[15:8], 1'b1);
      send_byte(chk[7:0], 1'b1);
    end
`else
    if (with_chk && chk != chk) send_byte(8'h00, 1'b1);
`endif
  endtask

  initial begin
    bit ed;
    int n;
    logic [15:0] chk;
    rst = 1'b1;
    uart_rx = 1'b1;

    // two words, with a busy check after the first byte
    do_reset();
    img[0] = 16'hA5C3;
    img[1] = 16'h1234;
    chk = xor_words(2);
    model_image(2, chk, ed);
    check("model_pin_w0", 64'(exp_q[0]), 64'({4'h0, 16'hA5C3}));
    check("model_pin_w1", 64'(exp_q[1]), 64'({4'h1, 16'h1234}));
    send_byte(8'h00, 1'b1);
    check("busy_during_load", {63'd0, busy}, 64'd1);
    send_byte(8'h02, 1'b1);
    for (int i = 0; i < 2; i++) begin
      send_byte(img[i][15:8], 1'b1);
      send_byte(img[i][7:0], 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(chk[15:8], 1'b1);
    send_byte(chk[7:0], 1'b1);
`endif
    wait_end();
    final_check("two_words", ed);
    // traffic after DONE is ignored
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (8) @(negedge clk);
    final_check("after_done", 1'b1);

    // empty image
    do_reset();
    model_image(0, 16'h0000, ed);
    send_image(16'h0000, 0, 16'h0000, 1'b1);
    wait_end();
    final_check("empty", ed);

    // oversize count: 17 > 16
    do_reset();
    model_image(17, 16'h0000, ed);
    check("model_pin_oversize", {63'd0, ed}, 64'd0);
    send_image(16'h0011, 0, 16'h0000, 1'b0);
    wait_end();
    final_check("oversize", ed);

    // framing error on first data byte, then valid bytes are ignored
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h5A, 1'b0);
    wait_end();
    final_check("frame_err", 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    repeat (8) @(negedge clk);
    final_check("frame_err_sticky", 1'b0);
    do_reset();

    // 1-cycle glitch while idle, then a normal image
    @(negedge clk);
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (4 * C) @(negedge clk);
    check("glitch_state", {60'd0, busy, done, err, cpu_rst}, 64'h1);
    img[0] = 16'hBEEF;
    chk = xor_words(1);
    model_image(1, chk, ed);
    send_image(16'h0001, 1, chk, 1'b1);
    wait_end();
    final_check("after_glitch", ed);

    // randomized images, first one fills every address
    for (int t = 0; t < 6; t++) begin
      do_reset();
      n = (t == 0) ? MAXW : $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) img[i] = 16'($urandom_range(0, 65535));
      chk = xor_words(n);
      model_image(n, chk, ed);
      send_image(16'(n), n, chk, 1'b1);
      wait_end();
      final_check("random", ed);
    end

`ifdef LOADER_CHECKSUM_EN
    // checksum match and mismatch
    img[0] = 16'h00FF;
    img[1] = 16'h0F0F;
    check("model_pin_xor", 64'(xor_words(2)), 64'h0FF0);
    do_reset();
    model_image(2, 16'h0FF0, ed);
    send_image(16'h0002, 2, 16'h0FF0, 1'b1);
    wait_end();
    final_check("chk_match", ed);
    do_reset();
    model_image(2, 16'h0000, ed);
    check("model_pin_mismatch", {63'd0, ed}, 64'd0);
    send_image(16'h0002, 2, 16'h0000, 1'b1);
    wait_end();
    final_check("chk_mismatch", ed);
`endif

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
